// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage with a two-entry skid buffer and a registered in_ready.
// Optional saturating stall counter (stall_cnt, CNT_W) built when PIPE_STALL_CNT_EN is defined.
module pipe_skid_stage #(
  parameter int unsigned WIDTH = 16
`ifdef PIPE_STALL_CNT_EN
  ,
  parameter int unsigned CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             w_out_valid_nxt;
  logic             w_in_ready_nxt;

  // State, storage and handshake flags; handshake flags are decoded from the next state
  // so both outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
    end
  end

  // Next-state and storage update; vacated registers are zeroed so idle out_data reads 0.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;

    case (r_state)
      ST_EMPTY: begin
        if (in_valid) begin
          w_state_nxt = ST_BUSY;
          w_main_nxt  = in_data;
        end
      end
      ST_BUSY: begin
        if (in_valid && out_ready) begin
          w_main_nxt = in_data;
        end else if (in_valid) begin
          w_state_nxt = ST_FULL;
          w_skid_nxt  = in_data;
        end else if (out_ready) begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = '0;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          w_state_nxt = ST_BUSY;
          w_main_nxt  = r_skid;
          w_skid_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_main_nxt  = '0;
        w_skid_nxt  = '0;
      end
    endcase

    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end

    w_out_valid_nxt = (w_state_nxt != ST_EMPTY);
    w_in_ready_nxt  = (w_state_nxt != ST_FULL);
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall_sat;

  assign w_stall_sat = &r_stall_cnt;

  // Counts output-side stall cycles; survives flush so debug totals span pipeline flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && !w_stall_sat) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed vector table, stall-counter sequence
// (when PIPE_STALL_CNT_EN is defined) and random traffic against a queue-based model.
module tb_pipe_skid_stage;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned NVEC  = 26;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

`ifdef PIPE_STALL_CNT_EN
  pipe_skid_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );
`else
  pipe_skid_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] in_data;
    logic             exp_out_valid;
    logic             exp_in_ready;
    logic [WIDTH-1:0] exp_out_data;
  } vec_t;

  vec_t vecs [NVEC];

  int n_checks;
  int n_pass;

  // Reference model: the stage is a FIFO of capacity two.
  logic [WIDTH-1:0] mq[$];
  int unsigned      m_stall;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endfunction

  function automatic void model_edge();
    logic m_ov;
    logic m_ir;
    m_ov = (mq.size() > 0);
    m_ir = (mq.size() < 2);
    if (rst) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (m_ov && !out_ready && m_stall < (2**CNT_W - 1)) m_stall++;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_ov && out_ready) void'(mq.pop_front());
        if (in_valid && m_ir) mq.push_back(in_data);
      end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    check({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() < 2));
    check({tag, ".out_data"},  32'(out_data),  (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
`ifdef PIPE_STALL_CNT_EN
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
`endif
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [WIDTH-1:0] d);
    rst = r; flush = f; in_valid = iv; out_ready = ordy; in_data = d;
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic ordy,
                              input logic [WIDTH-1:0] d, input logic eov, input logic eir,
                              input logic [WIDTH-1:0] eod);
    vec_t v;
    v.rst = r; v.flush = f; v.in_valid = iv; v.out_ready = ordy; v.in_data = d;
    v.exp_out_valid = eov; v.exp_in_ready = eir; v.exp_out_data = eod;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_stall  = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Reset
    vecs[0]  = mk(1, 0, 0, 0, 16'h0000, 0, 1, 16'h0000);
    vecs[1]  = mk(1, 0, 0, 0, 16'h0000, 0, 1, 16'h0000);
    // Streaming 1..8, one cycle latency
    for (int i = 0; i < 8; i++)
      vecs[2+i] = mk(0, 0, 1, 1, 16'(i + 1), 1, 1, 16'(i + 1));
    vecs[10] = mk(0, 0, 0, 1, 16'h0000, 0, 1, 16'h0000);
    // Backpressure, 0xCCCC held while in_ready=0
    vecs[11] = mk(0, 0, 1, 0, 16'hAAAA, 1, 1, 16'hAAAA);
    vecs[12] = mk(0, 0, 1, 0, 16'hBBBB, 1, 0, 16'hAAAA);
    vecs[13] = mk(0, 0, 1, 0, 16'hCCCC, 1, 0, 16'hAAAA);
    vecs[14] = mk(0, 0, 1, 1, 16'hCCCC, 1, 1, 16'hBBBB);
    vecs[15] = mk(0, 0, 1, 1, 16'hCCCC, 1, 1, 16'hCCCC);
    vecs[16] = mk(0, 0, 0, 1, 16'h0000, 0, 1, 16'h0000);
    // Flush while FULL with 0xDDDD offered
    vecs[17] = mk(0, 0, 1, 0, 16'h1111, 1, 1, 16'h1111);
    vecs[18] = mk(0, 0, 1, 0, 16'h2222, 1, 0, 16'h1111);
    vecs[19] = mk(0, 1, 1, 0, 16'hDDDD, 0, 1, 16'h0000);
    vecs[20] = mk(0, 0, 0, 1, 16'h0000, 0, 1, 16'h0000);
    // Reset mid-stream while BUSY
    vecs[21] = mk(0, 0, 1, 0, 16'h1234, 1, 1, 16'h1234);
    vecs[22] = mk(1, 0, 1, 0, 16'h5678, 0, 1, 16'h0000);
    vecs[23] = mk(0, 0, 0, 0, 16'h0000, 0, 1, 16'h0000);
    // Flush while BUSY with both handshakes active
    vecs[24] = mk(0, 0, 1, 0, 16'h9999, 1, 1, 16'h9999);
    vecs[25] = mk(0, 1, 1, 1, 16'hAAAA, 0, 1, 16'h0000);

    @(negedge clk);
    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready, vecs[i].in_data);
      tick();
      check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].exp_out_valid));
      check($sformatf("vec%0d.in_ready", i),  32'(in_ready),  32'(vecs[i].exp_in_ready));
      check($sformatf("vec%0d.out_data", i),  32'(out_data),  32'(vecs[i].exp_out_data));
    end

`ifdef PIPE_STALL_CNT_EN
    // Stall counter saturation and persistence across flush
    drive(1, 0, 0, 0, '0);
    tick();
    check("stall.reset", 32'(stall_cnt), 32'd0);
    drive(0, 0, 1, 0, 16'h0042);
    tick();
    check("stall.push", 32'(stall_cnt), 32'd0);
    drive(0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall.cyc%0d", i), 32'(stall_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    drive(0, 1, 0, 0, '0);
    tick();
    check("stall.flush_out_valid", 32'(out_valid), 32'd0);
    check("stall.after_flush", 32'(stall_cnt), 32'd3);
`endif

    // Random traffic; upstream holds a refused offer stable
    drive(1, 0, 0, 0, '0);
    tick();
    check_model("rnd.reset");
    for (int c = 0; c < 600; c++) begin
      logic hold;
      hold = in_valid && !rst && !in_ready;
      rst       = ($urandom_range(0, 79) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 16'($urandom);
      end
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
